// File: rtl/hpi_access_controller.sv
// HPI bus sequencer for the CY7C67200: round-robin arbitration between two requesters,
// direct register or address+data memory transactions with programmable strobe/recovery timing.
module hpi_access_controller #(
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        req0_we,
    input  logic        req1_we,
    input  logic        req0_direct,
    input  logic        req1_direct,
    input  logic [1:0]  req0_reg,
    input  logic [1:0]  req1_reg,
    input  logic [15:0] req0_addr,
    input  logic [15:0] req1_addr,
    input  logic [15:0] req0_wdata,
    input  logic [15:0] req1_wdata,
    output logic        req0_done,
    output logic        req1_done,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        hpi_cs_n,
    output logic        hpi_r_n,
    output logic        hpi_w_n,
    output logic [1:0]  hpi_addr,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    input  logic [15:0] hpi_data_in
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP, S_DONE} state_t;

    localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD    = 8'(GAP_CYCLES - 1);

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        phase, phase_nx;          // 0 = ADDR phase, 1 = DATA phase
    logic        grant, grant_nx;
    logic        last_grant, last_grant_nx;
    logic        cap_we, cap_we_nx;
    logic        cap_direct, cap_direct_nx;
    logic [1:0]  cap_reg, cap_reg_nx;
    logic [15:0] cap_addr, cap_addr_nx;
    logic [15:0] cap_wdata, cap_wdata_nx;
    logic [15:0] rdata_nx, data_out_nx;
    logic [1:0]  addr_nx;
    logic        cs_n_nx, r_n_nx, w_n_nx, oe_nx, done0_nx, done1_nx;
    logic        pick, phase_end, wr_cycle;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= S_IDLE;
            cnt          <= 8'd0;
            phase        <= 1'b0;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            cap_we       <= 1'b0;
            cap_direct   <= 1'b0;
            cap_reg      <= 2'b00;
            cap_addr     <= 16'h0000;
            cap_wdata    <= 16'h0000;
            rdata        <= 16'h0000;
            busy         <= 1'b0;
            hpi_cs_n     <= 1'b1;
            hpi_r_n      <= 1'b1;
            hpi_w_n      <= 1'b1;
            hpi_addr     <= 2'b00;
            hpi_data_out <= 16'h0000;
            hpi_data_oe  <= 1'b0;
            req0_done    <= 1'b0;
            req1_done    <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            phase        <= phase_nx;
            grant        <= grant_nx;
            last_grant   <= last_grant_nx;
            cap_we       <= cap_we_nx;
            cap_direct   <= cap_direct_nx;
            cap_reg      <= cap_reg_nx;
            cap_addr     <= cap_addr_nx;
            cap_wdata    <= cap_wdata_nx;
            rdata        <= rdata_nx;
            busy         <= (state_nx != S_IDLE);
            hpi_cs_n     <= cs_n_nx;
            hpi_r_n      <= r_n_nx;
            hpi_w_n      <= w_n_nx;
            hpi_addr     <= addr_nx;
            hpi_data_out <= data_out_nx;
            hpi_data_oe  <= oe_nx;
            req0_done    <= done0_nx;
            req1_done    <= done1_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        phase_nx      = phase;
        grant_nx      = grant;
        last_grant_nx = last_grant;
        cap_we_nx     = cap_we;
        cap_direct_nx = cap_direct;
        cap_reg_nx    = cap_reg;
        cap_addr_nx   = cap_addr;
        cap_wdata_nx  = cap_wdata;
        rdata_nx      = rdata;
        pick          = 1'b0;
        phase_end     = 1'b0;

        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    pick          = (req0 && req1) ? ~last_grant : req1;
                    grant_nx      = pick;
                    last_grant_nx = pick;
                    cap_we_nx     = pick ? req1_we     : req0_we;
                    cap_direct_nx = pick ? req1_direct : req0_direct;
                    cap_reg_nx    = pick ? req1_reg    : req0_reg;
                    cap_addr_nx   = pick ? req1_addr   : req0_addr;
                    cap_wdata_nx  = pick ? req1_wdata  : req0_wdata;
                    // direct accesses skip the ADDR phase entirely
                    phase_nx      = pick ? req1_direct : req0_direct;
                    state_nx      = S_SETUP;
                end
            end
            S_SETUP: begin
                state_nx = S_STROBE;
                cnt_nx   = STROBE_LOAD;
            end
            S_STROBE: begin
                if (cnt == 8'd0) begin
                    state_nx = S_HOLD;
                    if (phase && !cap_we)
                        rdata_nx = hpi_data_in;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            S_HOLD: begin
                if (GAP_CYCLES == 0) begin
                    phase_end = 1'b1;
                end else begin
                    state_nx = S_GAP;
                    cnt_nx   = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (cnt == 8'd0) phase_end = 1'b1;
                else             cnt_nx    = cnt - 8'd1;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        if (phase_end) begin
            if (!phase) begin
                phase_nx = 1'b1;
                state_nx = S_SETUP;
            end else begin
                state_nx = S_DONE;
            end
        end
    end

    // Bus outputs are registered, so they are derived from the state being entered.
    always_comb begin
        wr_cycle    = !phase_nx || cap_we_nx;
        cs_n_nx     = 1'b1;
        r_n_nx      = 1'b1;
        w_n_nx      = 1'b1;
        addr_nx     = hpi_addr;
        data_out_nx = hpi_data_out;
        oe_nx       = hpi_data_oe;
        done0_nx    = 1'b0;
        done1_nx    = 1'b0;

        case (state_nx)
            S_SETUP: begin
                cs_n_nx = 1'b0;
                addr_nx = !phase_nx ? 2'b10 : (cap_direct_nx ? cap_reg_nx : 2'b00);
                oe_nx   = wr_cycle;
                if (wr_cycle)
                    data_out_nx = !phase_nx ? cap_addr_nx : cap_wdata_nx;
            end
            S_STROBE: begin
                cs_n_nx = 1'b0;
                w_n_nx  = ~wr_cycle;
                r_n_nx  = wr_cycle;
            end
            S_HOLD: cs_n_nx = 1'b0;
            S_GAP:  oe_nx   = 1'b0;
            S_DONE: begin
                oe_nx    = 1'b0;
                done0_nx = ~grant_nx;
                done1_nx = grant_nx;
            end
            default: oe_nx = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_hpi_access_controller.sv
// Bench for hpi_access_controller: per-cycle expected bus waveform built from transaction
// timing rules (queue of expected cycles), directed scenarios followed by random traffic.
module tb_hpi_access_controller;
    localparam int S = 2;
    localparam int G = 1;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req0, req1, req0_we, req1_we, req0_direct, req1_direct;
    logic [1:0]  req0_reg, req1_reg;
    logic [15:0] req0_addr, req1_addr, req0_wdata, req1_wdata, hpi_data_in;

    logic        req0_done, req1_done, busy, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_data_oe;
    logic [15:0] rdata, hpi_data_out;
    logic [1:0]  hpi_addr;

    logic        req0_done_g, req1_done_g, busy_g, hpi_cs_n_g, hpi_r_n_g, hpi_w_n_g, hpi_data_oe_g;
    logic [15:0] rdata_g, hpi_data_out_g;
    logic [1:0]  hpi_addr_g;

    always #5 Clk = ~Clk;

    hpi_access_controller #(.STROBE_CYCLES(S), .GAP_CYCLES(G)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .req1(req1), .req0_we(req0_we), .req1_we(req1_we),
        .req0_direct(req0_direct), .req1_direct(req1_direct),
        .req0_reg(req0_reg), .req1_reg(req1_reg),
        .req0_addr(req0_addr), .req1_addr(req1_addr),
        .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
        .req0_done(req0_done), .req1_done(req1_done),
        .rdata(rdata), .busy(busy),
        .hpi_cs_n(hpi_cs_n), .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n),
        .hpi_addr(hpi_addr), .hpi_data_out(hpi_data_out), .hpi_data_oe(hpi_data_oe),
        .hpi_data_in(hpi_data_in)
    );

    hpi_access_controller #(.STROBE_CYCLES(2), .GAP_CYCLES(0)) dut_g (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .req1(req1), .req0_we(req0_we), .req1_we(req1_we),
        .req0_direct(req0_direct), .req1_direct(req1_direct),
        .req0_reg(req0_reg), .req1_reg(req1_reg),
        .req0_addr(req0_addr), .req1_addr(req1_addr),
        .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
        .req0_done(req0_done_g), .req1_done(req1_done_g),
        .rdata(rdata_g), .busy(busy_g),
        .hpi_cs_n(hpi_cs_n_g), .hpi_r_n(hpi_r_n_g), .hpi_w_n(hpi_w_n_g),
        .hpi_addr(hpi_addr_g), .hpi_data_out(hpi_data_out_g), .hpi_data_oe(hpi_data_oe_g),
        .hpi_data_in(hpi_data_in)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        cs_n, r_n, w_n;
        logic [1:0]  a;
        logic [15:0] d;
        logic        oe, d0, d1, latch;
    } exp_t;

    exp_t        q[$];
    logic        cur_busy, cur_latch, m_last;
    logic [1:0]  h_a;
    logic [15:0] h_d, m_rdata;

    function automatic exp_t mk(logic cs_n, logic r_n, logic w_n, logic [1:0] a, logic [15:0] d,
                                logic oe, logic d0, logic d1, logic latch);
        exp_t e;
        e.cs_n = cs_n; e.r_n = r_n; e.w_n = w_n; e.a = a; e.d = d;
        e.oe = oe; e.d0 = d0; e.d1 = d1; e.latch = latch;
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        cur_busy = 1'b0; cur_latch = 1'b0; m_last = 1'b1;
        h_a = 2'b00; h_d = 16'h0000; m_rdata = 16'h0000;
    endtask

    // Expected cycles of one transaction: per phase setup, S strobes, hold, G gaps; then done.
    task automatic push_txn(input logic who, input logic we, input logic direct, input logic [1:0] rg,
                            input logic [15:0] addr, input logic [15:0] wdata);
        logic [15:0] d;
        logic [1:0]  a;
        logic        wr;
        d = h_d;
        a = h_a;
        for (int p = (direct ? 1 : 0); p < 2; p++) begin
            wr = (p == 0) || we;
            a  = (p == 0) ? 2'b10 : (direct ? rg : 2'b00);
            if (wr) d = (p == 0) ? addr : wdata;
            q.push_back(mk(0, 1, 1, a, d, wr, 0, 0, 0));
            for (int s = 0; s < S; s++)
                q.push_back(mk(0, wr, !wr, a, d, wr, 0, 0, (!wr && s == S - 1)));
            q.push_back(mk(0, 1, 1, a, d, wr, 0, 0, 0));
            for (int g = 0; g < G; g++)
                q.push_back(mk(1, 1, 1, a, d, 0, 0, 0, 0));
        end
        q.push_back(mk(1, 1, 1, a, d, 0, !who, who, 0));
    endtask

    // Applies the inputs the DUT is about to sample at the coming edge.
    task automatic model_edge();
        logic who;
        if (Reset) begin
            model_reset();
            return;
        end
        if (cur_latch) m_rdata = hpi_data_in;
        if (!cur_busy && (req0 || req1)) begin
            who    = (req0 && req1) ? ~m_last : req1;
            m_last = who;
            if (who) push_txn(1'b1, req1_we, req1_direct, req1_reg, req1_addr, req1_wdata);
            else     push_txn(1'b0, req0_we, req0_direct, req0_reg, req0_addr, req0_wdata);
        end
    endtask

    task automatic check_cycle();
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            cur_busy = 1'b1;
        end else begin
            e = mk(1, 1, 1, h_a, h_d, 0, 0, 0, 0);
            cur_busy = 1'b0;
        end
        cur_latch = e.latch;
        h_a = e.a;
        h_d = e.d;
        check("cs_n",      32'(hpi_cs_n),     32'(e.cs_n));
        check("r_n",       32'(hpi_r_n),      32'(e.r_n));
        check("w_n",       32'(hpi_w_n),      32'(e.w_n));
        check("hpi_addr",  32'(hpi_addr),     32'(e.a));
        check("data_out",  32'(hpi_data_out), 32'(e.d));
        check("data_oe",   32'(hpi_data_oe),  32'(e.oe));
        check("done0",     32'(req0_done),    32'(e.d0));
        check("done1",     32'(req1_done),    32'(e.d1));
        check("busy",      32'(busy),         32'(cur_busy));
        check("rdata",     32'(rdata),        32'(m_rdata));
        check("done_excl", 32'(req0_done & req1_done), 32'd0);
    endtask

    task automatic tick();
        model_edge();
        @(posedge Clk);
        #1;
        check_cycle();
    endtask

    task automatic wait_done(input int which, output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if ((which == 0 && req0_done) || (which == 1 && req1_done)) begin
                n = i;
                if (which == 0) req0 = 1'b0;
                else            req1 = 1'b0;
                break;
            end
        end
    endtask

    task automatic randomize_inputs();
        req0        = ($urandom_range(0, 9) < 6);
        req1        = ($urandom_range(0, 9) < 6);
        req0_we     = 1'($urandom);
        req1_we     = 1'($urandom);
        req0_direct = 1'($urandom);
        req1_direct = 1'($urandom);
        req0_reg    = 2'($urandom);
        req1_reg    = 2'($urandom);
        req0_addr   = 16'($urandom);
        req1_addr   = 16'($urandom);
        req0_wdata  = 16'($urandom);
        req1_wdata  = 16'($urandom);
        hpi_data_in = 16'($urandom);
    endtask

    task automatic drain();
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < 40 && (busy || q.size() > 0); i++) tick();
        check("drain_idle", 32'(busy), 32'd0);
    endtask

    int n;
    int got;
    int order[4];

    initial begin
        model_reset();
        Reset = 1'b1;
        randomize_inputs();
        tick();
        randomize_inputs();
        tick();
        check("rst_cs_n", 32'(hpi_cs_n), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_oe", 32'(hpi_data_oe), 32'd0);
        Reset = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();

        // direct write to MAILBOX
        req0 = 1'b1; req0_we = 1'b1; req0_direct = 1'b1; req0_reg = 2'b01; req0_wdata = 16'h1234;
        wait_done(0, n);
        check("wr_latency", 32'(n), 32'd6);
        check("wr_rdata_held", 32'(rdata), 32'd0);
        drain();

        // memory read via ADDRESS then DATA
        req1 = 1'b1; req1_we = 1'b0; req1_direct = 1'b0; req1_addr = 16'h0514;
        hpi_data_in = 16'hBEEF;
        wait_done(1, n);
        check("mrd_latency", 32'(n), 32'd11);
        check("mrd_rdata", 32'(rdata), 32'h0000BEEF);
        drain();

        // contention from reset
        Reset = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        req0_direct = 1'b1; req1_direct = 1'b1; req0_we = 1'b1; req1_we = 1'b0;
        tick();
        Reset = 1'b0;
        got = 0;
        for (int k = 0; k < 4; k++) order[k] = -1;
        for (int i = 0; i < 100 && got < 4; i++) begin
            tick();
            req0 = 1'b1;
            req1 = 1'b1;
            if (req0_done) begin order[got] = 0; got++; req0 = 1'b0; end
            if (req1_done && got < 4) begin order[got] = 1; got++; req1 = 1'b0; end
        end
        check("cont_count", 32'(got), 32'd4);
        for (int k = 0; k < 4; k++) check("grant_order", 32'(order[k]), 32'(k % 2));
        drain();

        // reset at first STROBE cycle of a direct write
        req0 = 1'b1; req0_we = 1'b1; req0_direct = 1'b1; req0_reg = 2'b00; req0_wdata = 16'h5A5A;
        tick();
        req0 = 1'b0;
        tick();
        check("rm_strobe_w_n", 32'(hpi_w_n), 32'd0);
        Reset = 1'b1;
        tick();
        check("rm_w_n", 32'(hpi_w_n), 32'd1);
        check("rm_cs_n", 32'(hpi_cs_n), 32'd1);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_done0", 32'(req0_done), 32'd0);
        Reset = 1'b0;
        req1 = 1'b1; req1_we = 1'b0; req1_direct = 1'b1; req1_reg = 2'b00; hpi_data_in = 16'h00AA;
        wait_done(1, n);
        check("rm_rd_latency", 32'(n), 32'd6);
        check("rm_rd_rdata", 32'(rdata), 32'h000000AA);
        drain();

        // GAP_CYCLES=0 instance: direct read of STATUS
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        req0 = 1'b1; req0_we = 1'b0; req0_direct = 1'b1; req0_reg = 2'b11; hpi_data_in = 16'h0001;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i <= 4) begin
                check("g0_cs_n_low", 32'(hpi_cs_n_g), 32'd0);
                check("g0_done_early", 32'(req0_done_g), 32'd0);
            end else begin
                check("g0_done", 32'(req0_done_g), 32'd1);
                check("g0_cs_n_high", 32'(hpi_cs_n_g), 32'd1);
                check("g0_rdata", 32'(rdata_g), 32'd1);
                req0 = 1'b0;
            end
            if (i == 2) check("g0_addr", 32'(hpi_addr_g), 32'd3);
        end
        drain();

        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            Reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        Reset = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
